// File: rtl/pipeline_flush_ctrl_pkg.sv
// Shared encodings for the IF/ID flush controller and the decode-stage instruction mux.
package pipeline_flush_ctrl_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_FLUSH      = 2'd1;
  localparam logic [1:0] ST_WAIT_FETCH = 2'd2;
  localparam logic [1:0] ST_STALL_MEM  = 2'd3;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_TRAP   = 2'b10,
    PC_MEPC   = 2'b11
  } redirect_sel_e;

  // ADDI x0,x0,0 substituted by the decode mux while flush is high
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic redirect_sel_e redirect_code(input logic trap, input logic mret,
                                                  input logic branch);
    if (trap)        return PC_TRAP;
    else if (mret)   return PC_MEPC;
    else if (branch) return PC_BRANCH;
    else             return PC_SEQ;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: the EX load writes a register the ID instruction actually reads.
module load_use_detect (
  input  logic       ex_load,
  input  logic [4:0] ex_rd_addr,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  // x0 is never written, so a load targeting it cannot create a dependency
  assign hazard    = ex_load && (ex_rd_addr != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// IF/ID boundary controller: sequences flushes after redirects, load-use stalls
// and data-memory back-pressure.
//
// state         | meaning
// ST_RUN        | normal issue; redirects, hazards and fetch stalls evaluated
// ST_FLUSH      | flush_out high while the counter drains to 0
// ST_WAIT_FETCH | flush complete but fetch not ready; hold PC, keep flushing
// ST_STALL_MEM  | data memory busy; freeze front end, ignore redirects
module pipeline_flush_ctrl
  import pipeline_flush_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       trap_taken_in,
  input  logic       mret_in,
  input  logic       branch_taken_in,
  input  logic       instr_mem_ready_in,
  input  logic       data_mem_busy_in,
  input  logic       ex_load_in,
  input  logic [4:0] ex_rd_addr_in,
  input  logic [4:0] id_rs1_addr_in,
  input  logic [4:0] id_rs2_addr_in,
  input  logic       id_rs1_used_in,
  input  logic       id_rs2_used_in,
  output logic       flush_out,
  output logic [1:0] redirect_sel_out,
  output logic       pc_stall_out,
  output logic       if_id_stall_out,
  output logic       id_ex_bubble_out,
  output logic       busy_out
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             redirect_any;
  redirect_sel_e    redirect_code_c;

  load_use_detect u_load_use_detect (
    .ex_load     (ex_load_in),
    .ex_rd_addr  (ex_rd_addr_in),
    .id_rs1_addr (id_rs1_addr_in),
    .id_rs2_addr (id_rs2_addr_in),
    .id_rs1_used (id_rs1_used_in),
    .id_rs2_used (id_rs2_used_in),
    .hazard      (hazard)
  );

  assign redirect_any    = trap_taken_in || mret_in || branch_taken_in;
  assign redirect_code_c = redirect_code(trap_taken_in, mret_in, branch_taken_in);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_sel_out = PC_SEQ;
    pc_stall_out     = 1'b0;
    if_id_stall_out  = 1'b0;
    id_ex_bubble_out = 1'b0;
    if (!rst_in) begin
      case (state_q)
        ST_RUN: begin
          if (redirect_any) begin
            redirect_sel_out = redirect_code_c;
            state_d          = ST_FLUSH;
            cnt_d            = CNT_RELOAD;
          end else if (data_mem_busy_in) begin
            state_d = ST_STALL_MEM;
          end else if (hazard) begin
            pc_stall_out     = 1'b1;
            if_id_stall_out  = 1'b1;
            id_ex_bubble_out = 1'b1;
          end else if (!instr_mem_ready_in) begin
            pc_stall_out    = 1'b1;
            if_id_stall_out = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (redirect_any) begin
            redirect_sel_out = redirect_code_c;
            cnt_d            = CNT_RELOAD;
          end else if (cnt_q == '0) begin
            state_d = instr_mem_ready_in ? ST_RUN : ST_WAIT_FETCH;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_WAIT_FETCH: begin
          // a redirect must let the PC load its new target
          if (redirect_any) begin
            redirect_sel_out = redirect_code_c;
            state_d          = ST_FLUSH;
            cnt_d            = CNT_RELOAD;
          end else begin
            pc_stall_out = 1'b1;
            if (instr_mem_ready_in) state_d = ST_RUN;
          end
        end
        default: begin
          pc_stall_out    = 1'b1;
          if_id_stall_out = 1'b1;
          if (!data_mem_busy_in) state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      flush_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_out <= (state_d == ST_FLUSH) || (state_d == ST_WAIT_FETCH);
      busy_out  <= (state_d != ST_RUN);
    end
  end

endmodule
